peridot_board_uidreader: RTL

//  Sequencer that fetches the 64-bit unique ID from the EPCQ config flash using SPI command 0x4B.

---
 rtl/peridot_board_uidreader.sv | 300 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/peridot_board_uidreader.sv
// ---------------------------------------------------------------------------
// peridot_board_uidreader
//
// Purpose:
//   Reads the 64-bit unique ID of the EPCQ configuration flash with the
//   "read unique ID" command (0x4B). The shared flash SPI bus is acquired
//   through a req/gnt handshake with the bus arbiter. The bus is released
//   when the read is finished. The result is presented on spiuid /
//   spiuid_valid for the board EEPROM / romdata UID path.
//
// Optional feature (compile-time macro):
//   PERIDOT_UIDREADER_SANITY_EN
//     When defined, a UID of all zeros or all ones is treated as a failed
//     read. Such a read is repeated up to RETRY_MAX times. uid_error is
//     raised when every retry also fails. When the macro is not defined,
//     every UID is accepted and uid_error is tied low.
//
// Parameters:
//   CLOCKDIV   SCK half-period in clock_sig cycles (>= 1)
//   AUTOSTART  1: run one read right after reset release, 0: wait for start
//   CS_SETUP   clock_sig cycles between ncs low and the first SCK edge, and
//              between the last SCK edge and ncs high (>= 1)
//   RETRY_MAX  re-reads allowed on a failed sanity check (macro build only)
//
// Ports:
//   clock_sig     in   system clock
//   reset_sig     in   asynchronous, active-high reset
//   start         in   1-cycle pulse requesting a (re)read; ignored while busy
//   busy          out  high from an accepted start until DONE/ERROR
//   spi_req       out  bus request to the flash-bus arbiter
//   spi_gnt       in   bus grant; the SPI pins are driven only while it is high
//   spi_ncs       out  flash chip select, active low
//   spi_dclk      out  SCK, SPI mode 0 (idles low)
//   spi_asdo      out  MOSI
//   spi_data0     in   MISO
//   spiuid        out  UID; first received byte in [7:0], MSB first per byte
//   spiuid_valid  out  spiuid holds a completed read
//   uid_error     out  sanity retries exhausted
// ---------------------------------------------------------------------------
module peridot_board_uidreader #(
    parameter int CLOCKDIV  = 2,
    parameter int AUTOSTART = 1,
    parameter int CS_SETUP  = 2,
    parameter int RETRY_MAX = 3
) (
    input  logic        clock_sig,
    input  logic        reset_sig,
    input  logic        start,
    output logic        busy,
    output logic        spi_req,
    input  logic        spi_gnt,
    output logic        spi_ncs,
    output logic        spi_dclk,
    output logic        spi_asdo,
    input  logic        spi_data0,
    output logic [63:0] spiuid,
    output logic        spiuid_valid,
    output logic        uid_error
);

    localparam logic [7:0] READ_UID_CMD = 8'h4B;
    localparam logic [6:0] CMD_BITS     = 7'd8;
    // 8 command bits + 32 dummy bits + 64 data bits, counted 0..103
    localparam logic [6:0] LAST_BIT     = 7'd103;

    localparam int DIV_W = (CLOCKDIV > 1) ? $clog2(CLOCKDIV) : 1;
    localparam int CS_W  = (CS_SETUP > 1) ? $clog2(CS_SETUP) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLOCKDIV - 1);
    localparam logic [CS_W-1:0]  CS_LAST  = CS_W'(CS_SETUP - 1);

    if (CLOCKDIV < 1 || CS_SETUP < 1 || RETRY_MAX < 0 || AUTOSTART < 0 || AUTOSTART > 1) begin : g_bad_params
        $error("peridot_board_uidreader: need CLOCKDIV>=1, CS_SETUP>=1, RETRY_MAX>=0, AUTOSTART 0/1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_CSSETUP,
        S_SHIFT,
        S_CSHOLD,
        S_RELEASE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state, state_next;
    logic [CS_W-1:0]   cs_cnt, cs_cnt_next;
    logic [DIV_W-1:0]  div_cnt, div_cnt_next;
    logic [6:0]        bit_cnt, bit_cnt_next;
    logic              sck, sck_next;
    logic [63:0]       hold, hold_next;
    logic [63:0]       spiuid_next;
    logic              valid_next;
    logic              auto_pend, auto_next;
    logic              link_state;
    logic              link_up;

`ifdef PERIDOT_UIDREADER_SANITY_EN
    localparam int RETRY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(RETRY_MAX);

    logic [RETRY_W-1:0] retry_cnt, retry_next;
    logic               uid_error_reg, uid_error_next;
    logic               hold_bad;

    assign hold_bad  = (hold == 64'h0) || (&hold);
    assign uid_error = uid_error_reg;
`else
    assign uid_error = 1'b0;
`endif

    // The holding register collects bits MSB-first, so the first received
    // byte ends up in [63:56]; spiuid wants that byte in [7:0].
    function automatic logic [63:0] byte_order(input logic [63:0] shifted);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            r[8*k +: 8] = shifted[56 - 8*k +: 8];
        end
        return r;
    endfunction

    // States in which the chip select is asserted and a grant loss aborts.
    assign link_state = (state == S_CSSETUP) || (state == S_SHIFT) || (state == S_CSHOLD);
    assign link_up    = link_state && spi_gnt;

    // Pins are gated by spi_gnt directly so that they fall back to idle
    // levels in the same cycle the arbiter withdraws the grant.
    assign busy     = (state != S_IDLE);
    assign spi_req  = (state == S_REQ) || link_state;
    assign spi_ncs  = !link_up;
    assign spi_dclk = link_up && (state == S_SHIFT) && sck;
    assign spi_asdo = link_up && (state == S_SHIFT) && (bit_cnt < CMD_BITS)
                      && READ_UID_CMD[~bit_cnt[2:0]];

    always_comb begin
        state_next   = state;
        cs_cnt_next  = cs_cnt;
        div_cnt_next = div_cnt;
        bit_cnt_next = bit_cnt;
        sck_next     = sck;
        hold_next    = hold;
        spiuid_next  = spiuid;
        valid_next   = spiuid_valid;
        auto_next    = auto_pend;
`ifdef PERIDOT_UIDREADER_SANITY_EN
        retry_next     = retry_cnt;
        uid_error_next = uid_error_reg;
`endif

        if (link_state && !spi_gnt) begin
            // Grant lost mid-transaction: drop everything and queue up again
            // with the request still raised; the read restarts from the
            // command byte.
            state_next   = S_REQ;
            cs_cnt_next  = '0;
            div_cnt_next = '0;
            bit_cnt_next = '0;
            sck_next     = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start || auto_pend) begin
                        state_next = S_REQ;
                        auto_next  = 1'b0;
                        valid_next = 1'b0;
`ifdef PERIDOT_UIDREADER_SANITY_EN
                        uid_error_next = 1'b0;
                        retry_next     = '0;
`endif
                    end
                end

                S_REQ: begin
                    if (spi_gnt) begin
                        state_next = S_CSSETUP;
                    end
                end

                S_CSSETUP: begin
                    if (cs_cnt == CS_LAST) begin
                        cs_cnt_next = '0;
                        state_next  = S_SHIFT;
                    end else begin
                        cs_cnt_next = cs_cnt + 1'b1;
                    end
                end

                S_SHIFT: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt_next = div_cnt + 1'b1;
                    end else begin
                        div_cnt_next = '0;
                        sck_next     = !sck;
                        if (!sck) begin
                            // This cycle drives SCK high: capture MISO. All
                            // 104 bits pass through; only the last 64 remain.
                            hold_next = {hold[62:0], spi_data0};
                        end else if (bit_cnt == LAST_BIT) begin
                            state_next = S_CSHOLD;
                        end else begin
                            // Falling edge: advance so MOSI presents the next bit.
                            bit_cnt_next = bit_cnt + 1'b1;
                        end
                    end
                end

                S_CSHOLD: begin
                    if (cs_cnt == CS_LAST) begin
                        cs_cnt_next = '0;
                        state_next  = S_RELEASE;
                    end else begin
                        cs_cnt_next = cs_cnt + 1'b1;
                    end
                end

                S_RELEASE: begin
                    bit_cnt_next = '0;
                    state_next   = S_DONE;
                end

                S_DONE: begin
`ifdef PERIDOT_UIDREADER_SANITY_EN
                    if (hold_bad) begin
                        if (retry_cnt < RETRY_LIM) begin
                            retry_next = retry_cnt + 1'b1;
                            state_next = S_REQ;
                        end else begin
                            state_next = S_ERROR;
                        end
                    end else begin
                        spiuid_next = byte_order(hold);
                        valid_next  = 1'b1;
                        state_next  = S_IDLE;
                    end
`else
                    spiuid_next = byte_order(hold);
                    valid_next  = 1'b1;
                    state_next  = S_IDLE;
`endif
                end

                S_ERROR: begin
`ifdef PERIDOT_UIDREADER_SANITY_EN
                    uid_error_next = 1'b1;
                    valid_next     = 1'b0;
`endif
                    state_next = S_IDLE;
                end

                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock_sig or posedge reset_sig) begin
        if (reset_sig) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock_sig or posedge reset_sig) begin
        if (reset_sig) begin
            cs_cnt       <= '0;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            sck          <= 1'b0;
            spiuid       <= 64'h0;
            spiuid_valid <= 1'b0;
            auto_pend    <= (AUTOSTART != 0);
`ifdef PERIDOT_UIDREADER_SANITY_EN
            retry_cnt     <= '0;
            uid_error_reg <= 1'b0;
`endif
        end else begin
            cs_cnt       <= cs_cnt_next;
            div_cnt      <= div_cnt_next;
            bit_cnt      <= bit_cnt_next;
            sck          <= sck_next;
            spiuid       <= spiuid_next;
            spiuid_valid <= valid_next;
            auto_pend    <= auto_next;
`ifdef PERIDOT_UIDREADER_SANITY_EN
            retry_cnt     <= retry_next;
            uid_error_reg <= uid_error_next;
`endif
        end
    end

    // Holding register is pure data: always fully overwritten by a
    // complete transfer before it is consumed, so it needs no reset.
    always_ff @(posedge clock_sig) begin
        hold <= hold_next;
    end

endmodule
